// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one ALU between NUM_REQ requesters. A round-robin arbiter picks one
// pending request while idle, the latched opcode/operands are offered to the
// ALU until it accepts them, and the ALU's done/result (or a timeout abort)
// is returned as a one-cycle response tagged with the requester index.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, holds its payload stable until ready is
// seen. req_ready is asserted only for the granted requester, and only in
// the IDLE cycle in which it is granted. rsp_valid has no backpressure.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester request handshake
//   req_op/a/b          packed per-requester opcode (3b) and operands
//   alu_valid/ready     operation handshake to the ALU
//   alu_op/a/b          operation payload to the ALU
//   done, result        ALU completion pulse and result
//   rsp_valid/id/result/timeout   response bus
//   busy                high whenever a transaction is outstanding
//   dbg_state           current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ              = 4,
    parameter int ALU_IN_OP_WIDTH      = 8,
    parameter int ALU_OUT_RESULT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES       = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*3-1:0]                 req_op,
    input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]   req_b,
    output logic                                 alu_valid,
    input  logic                                 alu_ready,
    output logic [2:0]                           alu_op,
    output logic [ALU_IN_OP_WIDTH-1:0]           alu_a,
    output logic [ALU_IN_OP_WIDTH-1:0]           alu_b,
    input  logic                                 done,
    input  logic [ALU_OUT_RESULT_WIDTH-1:0]      result,
    output logic                                 rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]           rsp_id,
    output logic [ALU_OUT_RESULT_WIDTH-1:0]      rsp_result,
    output logic                                 rsp_timeout,
    output logic                                 busy,
    output logic [1:0]                           dbg_state
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int W = ALU_IN_OP_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ID_W-1:0]        ptr;        // last granted requester
    logic [ID_W-1:0]        lat_id;
    logic [2:0]             lat_op;
    logic [W-1:0]           lat_a;
    logic [W-1:0]           lat_b;
    logic [CNT_W-1:0]       cnt;

    logic                   grant_found;
    logic [ID_W-1:0]        grant_idx;
    int                     cand;

    // Round-robin search: start one past the last grant and wrap, so the
    // most recently served requester has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Request accept is gated by rst so nothing is acknowledged in a cycle
    // whose edge will discard it.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (grant_found)                state_next = ISSUE;
            ISSUE: if (alu_ready)                  state_next = WAIT;
            WAIT:  if (done || cnt == CNT_LAST)    state_next = RESP;
            RESP:                                  state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            lat_id      <= '0;
            lat_op      <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            cnt         <= '0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        lat_op <= req_op[int'(grant_idx)*3 +: 3];
                        lat_a  <= req_a[int'(grant_idx)*W +: W];
                        lat_b  <= req_b[int'(grant_idx)*W +: W];
                        lat_id <= grant_idx;
                        ptr    <= grant_idx;
                    end
                end
                ISSUE: begin
                    if (alu_ready) begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done takes precedence over an expiry in the same cycle
                    if (done) begin
                        rsp_result  <= result;
                        rsp_timeout <= 1'b0;
                        rsp_id      <= lat_id;
                    end else if (cnt == CNT_LAST) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_id      <= lat_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_valid = (state == ISSUE);
    assign alu_op    = lat_op;
    assign alu_a     = lat_a;
    assign alu_b     = lat_b;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// The bench plays both the requesters and the ALU. Expected grants come from
// a round-robin model phrased as "smallest forward distance from the last
// grant"; expected responses and their timing come from the transaction
// parameters chosen by each step (ALU accept delay, done delay, result).
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int RW  = 16;
  localparam int TO  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*3-1:0]  req_op;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            alu_valid;
  logic            alu_ready;
  logic [2:0]      alu_op;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic            done;
  logic [RW-1:0]   result;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [RW-1:0]   rsp_result;
  logic            rsp_timeout;
  logic            busy;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int last_g   = N - 1;
  logic [RW-1:0] exp_q[$];

  alu_share_arbiter #(
    .NUM_REQ(N), .ALU_IN_OP_WIDTH(W), .ALU_OUT_RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .done(done), .result(result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    alu_ready = 1'b0;
    done      = 1'b0;
    result    = '0;
    step();
    step();
    rst    = 1'b0;
    last_g = N - 1;
  endtask

  // Reference arbiter: the pending requester closest ahead of the last grant.
  function automatic int model_grant(input logic [N-1:0] v);
    int best;
    int best_d;
    int d;
    best   = -1;
    best_d = N + 1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - last_g - 1 + 2 * N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // One full transaction, starting in an idle cycle.
  //   rdy_wait : cycles alu_ready is held low before accepting
  //   done_k   : done arrives k cycles after the ALU handshake (0 = never)
  task automatic do_txn(input logic [N-1:0] v, input int rdy_wait, input int done_k,
                        input logic [RW-1:0] res, input bit keep_valid,
                        input bit fix, input logic [2:0] fop,
                        input logic [W-1:0] fa, input logic [W-1:0] fb);
    int g;
    int c;
    bit exp_to;
    logic [2:0] e_op;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    logic [N-1:0] onehot;

    g = model_grant(v);
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3] = 3'($urandom);
      req_a[W*i +: W]  = W'($urandom);
      req_b[W*i +: W]  = W'($urandom);
    end
    if (fix) begin
      req_op[3*g +: 3] = fop;
      req_a[W*g +: W]  = fa;
      req_b[W*g +: W]  = fb;
    end
    e_op = req_op[3*g +: 3];
    e_a  = req_a[W*g +: W];
    e_b  = req_b[W*g +: W];
    onehot = '0;
    onehot[g] = 1'b1;

    // accept cycle
    req_valid = v;
    alu_ready = 1'b0;
    done      = 1'b0;
    #1;
    chk("accept_ready", 32'(req_ready), 32'(onehot));
    chk("accept_busy", 32'(busy), 32'd0);
    last_g = g;
    step();
    if (!keep_valid) req_valid = '0;
    // operands change after the accept cycle; the latched copy must hold
    for (int i = 0; i < N; i++) req_a[W*i +: W] = W'($urandom);

    // issue phase; done during issue must be ignored
    for (int j = 0; j <= rdy_wait; j++) begin
      alu_ready = (j == rdy_wait);
      done      = 1'($urandom);
      result    = RW'($urandom);
      #1;
      chk("issue_valid", 32'(alu_valid), 32'd1);
      chk("issue_op", 32'(alu_op), 32'(e_op));
      chk("issue_a", 32'(alu_a), 32'(e_a));
      chk("issue_b", 32'(alu_b), 32'(e_b));
      chk("issue_ready0", 32'(req_ready), 32'd0);
      chk("issue_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    alu_ready = 1'b0;

    // wait phase: WAIT cycle c is c cycles after the handshake
    exp_to = !(done_k >= 1 && done_k <= TO);
    c = 1;
    while (1) begin
      done   = (c == done_k);
      result = (c == done_k) ? res : RW'($urandom);
      #1;
      chk("wait_rsp0", 32'(rsp_valid), 32'd0);
      chk("wait_alu0", 32'(alu_valid), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      step();
      if (c == done_k || c == TO) break;
      c++;
    end
    done = 1'b0;
    exp_q.push_back(exp_to ? RW'(0) : res);

    // response cycle
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_result", 32'(rsp_result), 32'(exp_q.pop_front()));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    step();
    #1;
    chk("post_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("post_rsp_hold_id", 32'(rsp_id), 32'(g));
    chk("post_rsp_hold_to", 32'(rsp_timeout), 32'(exp_to));
    chk("post_rsp_busy", 32'(busy), (keep_valid && v != 0) ? 32'd0 : 32'd0);
  endtask

  initial begin
    // reset state
    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // single ADD request from requester 0, done 3 cycles after handshake
    do_txn(4'b0001, 0, 3, 16'h0046, 1'b0, 1'b1, 3'b001, 8'h12, 8'h34);

    // all requesters held valid from reset: grants 0,1,2,3,0
    do_reset();
    for (int t = 0; t < 5; t++) begin
      do_txn(4'b1111, 0, $urandom_range(1, 4), RW'($urandom), 1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    end
    req_valid = '0;

    // ALU stalls the handshake for 5 cycles
    do_txn(4'b0100, 5, 2, 16'hbeef, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);

    // ALU never answers: timeout abort, then a normal transaction
    do_txn(4'b0010, 0, 0, 16'h1234, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    do_txn(4'b0001, 1, 2, 16'h5a5a, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);

    // done in the very cycle the timeout would expire
    do_txn(4'b1000, 0, TO, 16'hc0de, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);

    // reset while waiting for done
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    alu_ready = 1'b1;
    step();
    alu_ready = 1'b0;
    step();
    step();
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    last_g = N - 1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      done = 1'b1;
      #1;
      chk("mid_rst_quiet", 32'(rsp_valid), 32'd0);
      step();
    end
    done = 1'b0;
    do_txn(4'b1010, 0, 1, 16'h0f0f, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      do_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8),
             RW'($urandom), 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // hard stop in case the sequence is ever stalled
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU datapath between NUM_REQ independent requesters.
- Uses round-robin arbitration.
- Issues the winning request's opcode and operands to the ALU input side, then waits for the ALU output-side done/result.
- Returns the result, tagged with the requester ID, on a shared response bus.
- Sits between the requester masters and the ALU; the ALU-side ports mirror the ALU input and output bus signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_IN_OP_WIDTH, 8, operand width (A and B).
- ALU_OUT_RESULT_WIDTH, 16, result width.
- TIMEOUT_CYCLES, 64, maximum wait for done after issue before aborting (>=2).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  NUM_REQ*3  per-requester opcode; slice i = bits [3i+2:3i].
- req_a  input  NUM_REQ*ALU_IN_OP_WIDTH  per-requester operand A, packed like req_op.
- req_b  input  NUM_REQ*ALU_IN_OP_WIDTH  per-requester operand B, packed like req_op.
- alu_valid  output  1  operation valid to ALU.
- alu_ready  input  1  ALU accepts operation.
- alu_op  output  3  opcode to ALU.
- alu_a  output  ALU_IN_OP_WIDTH  operand A to ALU.
- alu_b  output  ALU_IN_OP_WIDTH  operand B to ALU.
- done  input  1  ALU result valid pulse.
- result  input  ALU_OUT_RESULT_WIDTH  ALU result, valid when done=1.
- rsp_valid  output  1  response valid; single-cycle pulse, no backpressure.
- rsp_id  output  clog2(NUM_REQ)  requester index of the response.
- rsp_result  output  ALU_OUT_RESULT_WIDTH  captured result.
- rsp_timeout  output  1  response is an abort (no done seen).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values:
  - state=IDLE.
  - Round-robin last-grant pointer = NUM_REQ-1, so requester 0 has top priority first.
  - alu_valid=0, alu_op/alu_a/alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_timeout=0.
  - req_ready=0, busy=0.
  - Timeout counter=0.
- IDLE:
  - If any req_valid, select the first asserted index searching from pointer+1 with wrap-around.
  - req_ready[g]=1 combinationally in that cycle.
  - Latch op/a/b/id of g, set pointer=g, go to ISSUE.
  - Only one request is accepted per cycle.
- ISSUE:
  - alu_valid=1 with the latched operands; hold them stable until alu_ready=1.
  - On alu_valid & alu_ready: clear the counter, go to WAIT.
  - alu_valid drops the cycle after the handshake.
  - done asserted in ISSUE is ignored.
- WAIT:
  - Counter increments each cycle.
  - On done=1: capture result into rsp_result, rsp_timeout=0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: rsp_result=0, rsp_timeout=1, go to RESP.
  - done in the same cycle as expiry: done wins (normal response).
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_id = latched id; then IDLE.
  - rsp_id, rsp_result and rsp_timeout hold their values until the next RESP.
- Latency:
  - Accept at cycle T; alu_valid at T+1.
  - With alu_ready tied 1 and done arriving k cycles after the handshake, rsp_valid occurs at T+k+2.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
- Requester contract:
  - A requester whose req_valid drops before being granted is simply skipped.
  - Operands are sampled only in the accept cycle.
- Reset mid-operation: return to IDLE immediately, with no response for the in-flight transaction and the pointer reset.
- No new request is accepted while busy=1; one transaction is outstanding at a time.

Test Plan:
- Single request: req_valid=4'b0001, op=ADD(3'b001), a=8'h12, b=8'h34; ALU returns done with result=16'h0046 three cycles after the handshake -> req_ready[0] in the accept cycle; alu_op=1, alu_a=8'h12, alu_b=8'h34; one rsp_valid pulse with rsp_id=0, rsp_result=16'h0046, rsp_timeout=0.
- All four requesters held valid continuously from reset -> grant order 0,1,2,3,0; each produces exactly one rsp_valid with the matching rsp_id.
- alu_ready held 0 for 5 cycles -> alu_valid high for 6 cycles with alu_op/alu_a/alu_b unchanged; WAIT entered after the handshake.
- ALU never asserts done, TIMEOUT_CYCLES=64 -> rsp_valid 64 cycles after WAIT entry, with rsp_timeout=1 and rsp_result=0; the next request is then accepted normally.
- done asserted in the exact cycle the counter reaches 63 -> rsp_timeout=0, rsp_result equals the ALU result.
- rst pulsed for 1 cycle during WAIT -> next cycle busy=0, no rsp_valid; with req_valid=4'b1010 the next grant goes to requester 1.
